// File: rtl/pes_ram_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// FSM state encoding, default widths and requester count.
package pes_ram_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 16;
  localparam int unsigned NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/pes_ram_arb_pick.sv
// Winner selection for two requesters.
// On a tie the preferred requester (i_rr_ptr) wins.
module pes_ram_arb_pick
  import pes_ram_pkg::*;
(
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_rr_ptr,
  output logic            o_winner,
  output logic            o_any
);

  // Lone requester always wins; a tie goes to the preferred one.
  always_comb begin
    o_any    = |i_valid;
    o_winner = 1'b0;
    if (&i_valid)
      o_winner = i_rr_ptr;
    else
      o_winner = i_valid[1];
  end

endmodule

// File: rtl/pes_ram_arbiter.sv
// Two-requester arbiter in front of a 1-cycle synchronous-read RAM.
// PES_RAM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no rr_ptr).
module pes_ram_arbiter
  import pes_ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic [15:0]   txn_count
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_grant;
  logic [15:0]   r_txn_count;
  logic          w_rr_ptr;
  logic          w_winner;
  logic          w_any;
  logic          w_accept;

`ifdef PES_RAM_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = 1'b0;
`else
  logic r_rr_ptr;

  // Preference flips to the other requester after each grant.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      r_rr_ptr <= 1'b0;
    else if (w_accept)
      r_rr_ptr <= ~w_winner;
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  pes_ram_arb_pick u_pick (
    .i_valid  ({req1_valid, req0_valid}),
    .i_rr_ptr (w_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Latch the winner's request at accept time.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= 1'b0;
    end else if (w_accept) begin
      r_grant <= w_winner;
      if (w_winner) begin
        r_we    <= req1_we;
        r_addr  <= req1_addr;
        r_wdata <= req1_wdata;
      end else begin
        r_we    <= req0_we;
        r_addr  <= req0_addr;
        r_wdata <= req0_wdata;
      end
    end
  end

  // Completed-transaction counter; wraps naturally at 16 bits.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      r_txn_count <= '0;
    else if (r_state == RESP)
      r_txn_count <= r_txn_count + 16'd1;
  end

  // Next state and all handshake / RAM / response outputs.
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_rdata  = '0;
    rsp1_rdata  = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          req0_ready  = ~w_winner;
          req1_ready  = w_winner;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ram_en      = 1'b1;
        ram_we      = r_we;
        ram_addr    = r_addr;
        ram_wdata   = r_wdata;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (r_grant) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = r_we ? '0 : ram_rdata;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = r_we ? '0 : ram_rdata;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign grant_id  = r_grant;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_pes_ram_arbiter.sv
// Directed self-checking bench for pes_ram_arbiter.
// Includes a behavioural 1-cycle synchronous-read RAM.
module tb_pes_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [7:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [7:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        busy, grant_id;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  // Behavioural RAM: write-first not needed, read data next cycle.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  pes_ram_arbiter dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .grant_id   (grant_id),
    .txn_count  (txn_count)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    ram_rdata = 0;
    tick();
    tick();
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
         ram_en, ram_we, busy, grant_id} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
        {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
         ram_en, ram_we, busy, grant_id});
    end
    checks++;
    if ({txn_count, ram_addr, ram_wdata, rsp0_rdata, rsp1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: txn=%h addr=%h wd=%h r0=%h r1=%h want 0",
        txn_count, ram_addr, ram_wdata, rsp0_rdata, rsp1_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    req0_valid = 1; req0_we = 1; req0_addr = 8'h21; req0_wdata = 16'h372C;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wr_ready: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0; req0_addr = 0; req0_wdata = 0;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, busy} !== {2'b11, 8'h21, 16'h372C, 1'b1}) begin
      errors++;
      $display("FAIL wr_issue: en=%b we=%b a=%h d=%h busy=%b want 1 1 21 372c 1",
        ram_en, ram_we, ram_addr, ram_wdata, busy);
    end
    tick();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata, ram_en, grant_id} !== {2'b10, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_resp: v0=%b v1=%b rd=%h en=%b gid=%b want 1 0 0000 0 0",
        rsp0_valid, rsp1_valid, rsp0_rdata, ram_en, grant_id);
    end
    tick();
    checks++;
    if ({txn_count, busy, rsp0_valid} !== {16'd1, 2'b00}) begin
      errors++;
      $display("FAIL wr_txn: txn=%0d busy=%b v0=%b want 1 0 0",
        txn_count, busy, rsp0_valid);
    end
  endtask

  task automatic test_read_back();
    req1_valid = 1; req1_we = 0; req1_addr = 8'h21;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_ready: got %b want 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 0;
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h21}) begin
      errors++;
      $display("FAIL rd_issue: en=%b we=%b a=%h want 1 0 21",
        ram_en, ram_we, ram_addr);
    end
    tick();
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp1_rdata, grant_id} !== {2'b10, 16'h372C, 1'b1}) begin
      errors++;
      $display("FAIL rd_resp: v1=%b v0=%b rd=%h gid=%b want 1 0 372c 1",
        rsp1_valid, rsp0_valid, rsp1_rdata, grant_id);
    end
    tick();
    checks++;
    if ({txn_count, grant_id, rsp1_rdata} !== {16'd2, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL rd_idle: txn=%0d gid=%b rd=%h want 2 1 0000",
        txn_count, grant_id, rsp1_rdata);
    end
  endtask

  task automatic test_withdraw();
    bit seen0;
    seen0 = 0;
    req1_valid = 1; req1_we = 0; req1_addr = 8'h21;
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_we = 1; req0_addr = 8'h40; req0_wdata = 16'hBEEF;
    #1;
    checks++;
    if ({busy, req0_ready, req1_ready} !== 3'b100) begin
      errors++;
      $display("FAIL wd_issue_ready: busy/r0/r1=%b want 100",
        {busy, req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp0_valid || req0_ready || (ram_en && ram_addr == 8'h40)) seen0 = 1;
      tick();
    end
    checks++;
    if (seen0 !== 1'b0) begin
      errors++;
      $display("FAIL wd_never: req0 activity=%b want 0", seen0);
    end
    checks++;
    if ({txn_count, grant_id} !== {16'd3, 1'b1}) begin
      errors++;
      $display("FAIL wd_txn: txn=%0d gid=%b want 3 1", txn_count, grant_id);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    seen = 0;
    req0_valid = 1; req0_we = 1; req0_addr = 8'h05; req0_wdata = 16'h1234;
    tick();
    req0_valid = 0;
    checks++;
    if ({ram_en, ram_we} !== 2'b11) begin
      errors++;
      $display("FAIL rm_issue: en/we=%b want 11", {ram_en, ram_we});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_en, ram_we, busy, txn_count} !== {3'b000, 16'd0}) begin
      errors++;
      $display("FAIL rm_async: en=%b we=%b busy=%b txn=%0d want 0 0 0 0",
        ram_en, ram_we, busy, txn_count);
    end
    tick();
    if (rsp0_valid || rsp1_valid) seen = 1;
    rst = 1'b0;
    req1_valid = 1; req1_we = 0; req1_addr = 8'h21;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rm_first_accept: r1/r0=%b want 10", {req1_ready, req0_ready});
    end
    tick();
    req1_valid = 0;
    if (rsp0_valid) seen = 1;
    tick();
    if (rsp0_valid) seen = 1;
    checks++;
    if ({rsp1_valid, rsp1_rdata} !== {1'b1, 16'h372C}) begin
      errors++;
      $display("FAIL rm_after: v1=%b rd=%h want 1 372c", rsp1_valid, rsp1_rdata);
    end
    tick();
    checks++;
    if ({seen, txn_count} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL rm_norsp: stray=%b txn=%0d want 0 1", seen, txn_count);
    end
  endtask

  task automatic test_wrap_boundary();
    force dut.r_txn_count = 16'hFFFF;
    #1;
    release dut.r_txn_count;
    #1;
    req0_valid = 1; req0_we = 1; req0_addr = 8'hFF; req0_wdata = 16'hA5A5;
    tick();
    req0_valid = 0;
    checks++;
    if ({ram_en, ram_addr, ram_wdata, txn_count} !== {1'b1, 8'hFF, 16'hA5A5, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_issue: en=%b a=%h d=%h txn=%h want 1 ff a5a5 ffff",
        ram_en, ram_addr, ram_wdata, txn_count);
    end
    tick();
    tick();
    checks++;
    if (txn_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_txn: txn=%h want 0000", txn_count);
    end
    req1_valid = 1; req1_we = 0; req1_addr = 8'hFF;
    tick();
    req1_valid = 0;
    tick();
    checks++;
    if ({rsp1_valid, rsp1_rdata} !== {1'b1, 16'hA5A5}) begin
      errors++;
      $display("FAIL boundary_rd: v1=%b rd=%h want 1 a5a5", rsp1_valid, rsp1_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    rst = 1'b1;
    req0_valid = 1; req0_we = 0; req0_addr = 8'h21;
    req1_valid = 1; req1_we = 0; req1_addr = 8'hFF;
    tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp = 2'b00;
      if (c % 3 == 0) begin
`ifdef PES_RAM_ARB_FIXED_PRIO_EN
        exp = 2'b01;
`else
        exp = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      end
      checks++;
      if ({req1_ready, req0_ready} !== exp) begin
        errors++;
        $display("FAIL contend_c%0d: r1r0=%b want %b", c, {req1_ready, req0_ready}, exp);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_withdraw();
    test_reset_mid_op();
    test_wrap_boundary();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
